// File: rtl/mdu_sequencer.sv
// Iterative 32-step multiply/divide unit that owns HI/LO and stalls the core while busy.
// Optional signed support is built only when MDU_SIGNED_EN is defined.
module mdu_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             sgn,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             rd_req,
   input  logic             rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic             stall
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | one multiply/divide iteration per clock (or divide-by-zero shortcut)
   // FIX   | sign correction of HI/LO (MDU_SIGNED_EN only)
   // DONE  | HI/LO just updated; a new start may be accepted
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
`ifdef MDU_SIGNED_EN
   localparam logic [1:0] FIX  = 2'd2;
`endif
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [CNTW-1:0]  cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] b;
   logic             op_r;
   logic             dz_pend;
   logic             dz_case;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rsh;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] q_nx;

`ifdef MDU_SIGNED_EN
   logic a_neg, b_neg;
   logic fix_r, neg_r, rneg_r;
   assign a_neg = sgn & srca[WIDTH-1];
   assign b_neg = sgn & srcb[WIDTH-1];
   assign a_mag = a_neg ? -srca : srca;
   assign b_mag = b_neg ? -srcb : srcb;
`else
   logic sgn_unused;
   assign sgn_unused = sgn;
   assign a_mag = srca;
   assign b_mag = srcb;
`endif

   assign dz_case = op & (srcb == '0);

   always_comb begin
      sum  = {1'b0, acc} + {1'b0, (q[0] ? b : '0)};
      rsh  = {acc, q[WIDTH-1]};
      diff = rsh[WIDTH-1:0] - b;
      if (op_r) begin
         // remainder after a successful subtract is below the divisor, so WIDTH bits suffice
         if (rsh >= {1'b0, b}) begin
            acc_nx = diff;
            q_nx   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx = rsh[WIDTH-1:0];
            q_nx   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx = sum[WIDTH:1];
         q_nx   = {sum[0], q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hi      <= '0;
         lo      <= '0;
         dz      <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         q       <= '0;
         b       <= '0;
         op_r    <= 1'b0;
         dz_pend <= 1'b0;
`ifdef MDU_SIGNED_EN
         fix_r   <= 1'b0;
         neg_r   <= 1'b0;
         rneg_r  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  op_r    <= op;
                  cnt     <= '0;
                  dz      <= 1'b0;
                  acc     <= '0;
                  b       <= b_mag;
                  q       <= dz_case ? srca : a_mag;
                  dz_pend <= dz_case;
`ifdef MDU_SIGNED_EN
                  fix_r   <= sgn & ~dz_case;
                  neg_r   <= a_neg ^ b_neg;
                  rneg_r  <= a_neg;
`endif
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (dz_pend) begin
                  lo    <= '1;
                  hi    <= q;
                  dz    <= 1'b1;
                  state <= DONE;
               end else begin
                  acc <= acc_nx;
                  q   <= q_nx;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNTW'(WIDTH-1)) begin
                     hi <= acc_nx;
                     lo <= q_nx;
`ifdef MDU_SIGNED_EN
                     state <= fix_r ? FIX : DONE;
`else
                     state <= DONE;
`endif
                  end
               end
            end
`ifdef MDU_SIGNED_EN
            FIX: begin
               if (op_r) begin
                  lo <= neg_r ? -lo : lo;
                  hi <= rneg_r ? -hi : hi;
               end else if (neg_r) begin
                  {hi, lo} <= -{hi, lo};
               end
               state <= DONE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign stall   = busy & ~done & (rd_req | start);
   assign rd_data = rd_sel ? hi : lo;

endmodule
